// File: rtl/serial_add_ctrl.sv
// Wide add/subtract sequencer that reuses one external 4-bit adder slice.
// Operands are processed one nibble per cycle, LSB first, with the carry held in a register between nibbles.
module serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] SUM,
  output logic             CO,
  output logic             Ofl,
  output logic [3:0]       add_A,
  output logic [3:0]       add_B,
  output logic             add_CI,
  input  logic [3:0]       add_SUM,
  input  logic             add_CO,
  input  logic             add_Ofl
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIB - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [IW-1:0]    r_idx;
  logic [WIDTH-1:0] r_sum_tmp;
  logic [WIDTH-1:0] r_sum;
  logic             r_co;
  logic             r_ofl;

  logic             w_run;
  logic [WIDTH-1:0] w_sum_full;

  assign w_run = (r_state == S_RUN);

  // Partial result with the current slice output merged in; on the last
  // nibble this is the complete sum.
  always_comb begin
    w_sum_full = r_sum_tmp;
    w_sum_full[4*r_idx +: 4] = add_SUM;
  end

  assign add_A  = w_run ? r_a[4*r_idx +: 4] : 4'd0;
  assign add_B  = w_run ? r_b[4*r_idx +: 4] : 4'd0;
  assign add_CI = w_run ? r_carry : 1'b0;

  assign busy = w_run;
  assign done = (r_state == S_DONE);
  assign SUM  = r_sum;
  assign CO   = r_co;
  assign Ofl  = r_ofl;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_carry   <= 1'b0;
      r_idx     <= '0;
      r_sum_tmp <= '0;
      r_sum     <= '0;
      r_co      <= 1'b0;
      r_ofl     <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          r_sum_tmp <= w_sum_full;
          r_carry   <= add_CO;
          r_idx     <= r_idx + IW'(1);
          if (r_idx == LAST_IDX) begin
            r_sum   <= w_sum_full;
            r_co    <= add_CO;
            r_ofl   <= add_Ofl;
            r_state <= S_DONE;
          end
        end
        default: begin
          // IDLE and DONE both accept a new request; subtraction is A + ~B + 1.
          if (start) begin
            r_a     <= A;
            r_b     <= sub ? ~B : B;
            r_carry <= sub;
            r_idx   <= '0;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: directed and random operations checked against
// full-width arithmetic, with a behavioural 4-bit slice attached.
module tb_serial_add_ctrl;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic         done;
  logic [W-1:0] SUM;
  logic         CO;
  logic         Ofl;
  logic [3:0]   add_A;
  logic [3:0]   add_B;
  logic         add_CI;
  logic [3:0]   add_SUM;
  logic         add_CO;
  logic         add_Ofl;
  logic [3:0]   low3;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_sum;
  logic         exp_co;
  logic         exp_ofl;

  always #5 clk = ~clk;

  // 4-bit slice: sum, carry out, and overflow as carry-out xor carry into bit 3.
  assign {add_CO, add_SUM} = {1'b0, add_A} + {1'b0, add_B} + {4'd0, add_CI};
  assign low3    = {1'b0, add_A[2:0]} + {1'b0, add_B[2:0]} + {3'd0, add_CI};
  assign add_Ofl = add_CO ^ low3[3];

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .A(A), .B(B),
    .busy(busy), .done(done), .SUM(SUM), .CO(CO), .Ofl(Ofl),
    .add_A(add_A), .add_B(add_B), .add_CI(add_CI),
    .add_SUM(add_SUM), .add_CO(add_CO), .add_Ofl(add_Ofl)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain full-width arithmetic on the effective operands.
  function automatic logic [W+1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic [W-1:0] bm;
    logic [W:0]   t;
    logic         ofl;
    bm  = s ? ~b : b;
    t   = {1'b0, a} + {1'b0, bm} + {{W{1'b0}}, s};
    ofl = (a[W-1] == bm[W-1]) && (t[W-1] != a[W-1]);
    return {ofl, t};
  endfunction

  // Carry entering nibble n of the full-width operation.
  function automatic logic carry_in(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input int n);
    logic [31:0] mask;
    logic [31:0] bm;
    logic [31:0] t;
    mask = (32'd1 << (4 * n)) - 32'd1;
    bm   = {16'd0, (s ? ~b : b)};
    t    = ({16'd0, a} & mask) + (bm & mask) + {31'd0, s};
    return t[4*n];
  endfunction

  // Called at a negedge; returns at the negedge of the DONE cycle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input logic hold, input logic [W-1:0] na, input logic [W-1:0] nb, input logic ns);
    logic [W+1:0] r;
    logic [W-1:0] bm;
    r  = ref_op(a, b, s);
    bm = s ? ~b : b;
    start = 1'b1; A = a; B = b; sub = s;
    @(posedge clk); #1;
    if (hold) begin
      start = 1'b1; A = na; B = nb; sub = ns;
    end else begin
      start = 1'b0; A = W'($urandom); B = W'($urandom); sub = 1'($urandom);
    end
    for (int n = 0; n < NIB; n++) begin
      @(negedge clk);
      check($sformatf("busy[%0d]", n), {31'd0, busy}, 32'd1);
      check($sformatf("nodone[%0d]", n), {31'd0, done}, 32'd0);
      check($sformatf("addA[%0d]", n), {28'd0, add_A}, {28'd0, a[4*n +: 4]});
      check($sformatf("addB[%0d]", n), {28'd0, add_B}, {28'd0, bm[4*n +: 4]});
      check($sformatf("addCI[%0d]", n), {31'd0, add_CI}, {31'd0, carry_in(a, b, s, n)});
      check($sformatf("sum_hold[%0d]", n), {16'd0, SUM}, {16'd0, exp_sum});
    end
    @(negedge clk);
    exp_sum = r[W-1:0]; exp_co = r[W]; exp_ofl = r[W+1];
    $display("op a=%h b=%h sub=%0d -> SUM=%h CO=%0d Ofl=%0d", a, b, s, SUM, CO, Ofl);
    check("done", {31'd0, done}, 32'd1);
    check("busy_done", {31'd0, busy}, 32'd0);
    check("SUM", {16'd0, SUM}, {16'd0, exp_sum});
    check("CO", {31'd0, CO}, {31'd0, exp_co});
    check("Ofl", {31'd0, Ofl}, {31'd0, exp_ofl});
    check("addA_done", {27'd0, add_A, add_CI}, 32'd0);
  endtask

  task automatic check_idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check("idle_done", {31'd0, done}, 32'd0);
      check("idle_busy", {31'd0, busy}, 32'd0);
      check("idle_SUM", {16'd0, SUM}, {16'd0, exp_sum});
      check("idle_COOfl", {30'd0, CO, Ofl}, {30'd0, exp_co, exp_ofl});
      check("idle_add", {23'd0, add_A, add_B, add_CI}, 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sub = 1'b0; A = '0; B = '0;
    exp_sum = '0; exp_co = 1'b0; exp_ofl = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_SUM", {16'd0, SUM}, 32'd0);
    check("rst_COOfl", {30'd0, CO, Ofl}, 32'd0);
    check("rst_add", {23'd0, add_A, add_B, add_CI}, 32'd0);
    rst = 1'b0;
    check_idle(2);

    // Directed cases
    run_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    check("t1_sum", {16'd0, SUM}, 32'h2233);
    check("t1_flags", {30'd0, CO, Ofl}, 32'd0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    check("t2_sum", {16'd0, SUM}, 32'h8000);
    check("t2_flags", {30'd0, CO, Ofl}, 32'd1);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    check("t3_sum", {16'd0, SUM}, 32'h0000);
    check("t3_flags", {30'd0, CO, Ofl}, 32'd2);
    run_op(16'h0005, 16'h0007, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
    check("t4_sum", {16'd0, SUM}, 32'hFFFE);
    check("t4_flags", {30'd0, CO, Ofl}, 32'd0);
    run_op(16'h8000, 16'h0001, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
    check("t5_sum", {16'd0, SUM}, 32'h7FFF);
    check("t5_flags", {30'd0, CO, Ofl}, 32'd3);

    // Start held high: ignored while busy, accepted in the DONE cycle
    run_op(16'h1111, 16'h2222, 1'b0, 1'b1, 16'hAAAA, 16'h5555, 1'b0);
    check("b2b1_sum", {16'd0, SUM}, 32'h3333);
    run_op(16'hAAAA, 16'h5555, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    check("b2b2_sum", {16'd0, SUM}, 32'hFFFF);
    check("b2b2_flags", {30'd0, CO, Ofl}, 32'd0);

    // Reset in the third RUN cycle aborts the operation
    @(negedge clk);
    start = 1'b1; A = 16'h4321; B = 16'h1234; sub = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_sum = '0; exp_co = 1'b0; exp_ofl = 1'b0;
    $display("abort: busy=%0d done=%0d SUM=%h", busy, done, SUM);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_SUM", {16'd0, SUM}, 32'd0);
    check_idle(NIB + 2);
    run_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    check("post_rst_sum", {16'd0, SUM}, 32'h1000);

    // Idle hold after completion
    @(negedge clk);
    check_idle(10);

    // Random operations, occasionally back-to-back
    for (int i = 0; i < 24; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rs;
      ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom);
      if (i % 4 == 3) begin
        logic [W-1:0] ra2;
        logic [W-1:0] rb2;
        logic         rs2;
        ra2 = W'($urandom); rb2 = W'($urandom); rs2 = 1'($urandom);
        run_op(ra, rb, rs, 1'b1, ra2, rb2, rs2);
        run_op(ra2, rb2, rs2, 1'b0, 16'h0, 16'h0, 1'b0);
      end else begin
        run_op(ra, rb, rs, 1'b0, 16'h0, 16'h0, 1'b0);
      end
      @(negedge clk);
    end
    check_idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
